// File: rtl/fwrisc_dbus_initiator.sv
// Data-bus initiator for the FWRISC daddr/dwdata/dwstb/dwrite/dvalid/dready bus.
// It accepts one load/store request at a time and returns extended read data or an error.
module fwrisc_dbus_initiator #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwstb,
    output logic        dwrite,
    output logic        dvalid,
    input  logic        dready,
    input  logic [31:0] drdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] wait_cnt_next;
    logic [1:0]           lane;
    logic [1:0]           size_q;
    logic                 unsigned_q;

    logic                 misaligned;
    logic [3:0]           req_stb;
    logic [31:0]          req_data;
    logic [31:0]          lane_data;
    logic [31:0]          load_data;
    logic                 timeout_hit;

    // Held low during reset so nothing can be accepted while the block is being cleared.
    assign req_ready     = reset && (state == IDLE);
    assign wait_cnt_next = wait_cnt + CNT_ONE;
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt_next == TIMEOUT_LIMIT);

    always_comb begin
        misaligned = 1'b0;
        req_stb    = 4'hF;
        req_data   = req_wdata;
        case (req_size)
            2'd0: begin
                req_stb  = 4'b0001 << req_addr[1:0];
                req_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = req_addr[0];
                req_stb    = 4'b0011 << req_addr[1:0];
                req_data   = {2{req_wdata[15:0]}};
            end
            2'd2: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend according to the access size.
    always_comb begin
        lane_data = drdata >> {lane, 3'b000};
        load_data = drdata;
        case (size_q)
            2'd0: load_data = unsigned_q ? {24'h0, lane_data[7:0]}
                                         : {{24{lane_data[7]}}, lane_data[7:0]};
            2'd1: load_data = unsigned_q ? {16'h0, lane_data[15:0]}
                                         : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_data = drdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lane       <= 2'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            daddr      <= 32'h0;
            dwdata     <= 32'h0;
            dwstb      <= 4'h0;
            dwrite     <= 1'b0;
            dvalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wait_cnt <= '0;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= RESP;
                        end else begin
                            daddr      <= {req_addr[31:2], 2'b00};
                            dwdata     <= req_data;
                            dwstb      <= req_stb;
                            dwrite     <= req_write;
                            dvalid     <= 1'b1;
                            lane       <= req_addr[1:0];
                            size_q     <= req_size;
                            unsigned_q <= req_unsigned;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // A completion on the timeout edge takes priority over the abort.
                    if (dready) begin
                        dvalid    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= dwrite ? 32'h0 : load_data;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                        if (timeout_hit) begin
                            dvalid    <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
